// File: rtl/ni_packetizer.sv
// rtl/ni_packetizer.sv - network-interface transmitter: send request -> HEADER/PAYLOAD*/TAIL flits
// Optional feature macro: NI_CHECKSUM_EN (TAIL carries XOR of payload words; default build: zero tail)
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cur_addr            own tile address {y,x}, latched at request accept
//   req/req_dst/req_len send request, destination, payload flit count; req_ack pulses on accept
//   dat_valid/dat       payload word in; dat_ready marks the word consumed this cycle
//   out_full            router local FIFO full; out_valid/flit_out flit toward that FIFO
//   busy                packet in progress; pkt_cnt counts transferred TAIL flits (wraps)
module ni_packetizer #(
  parameter int FLIT_W  = 32,
  parameter int MAX_LEN = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cur_addr,
  input  logic              req,
  input  logic [3:0]        req_dst,
  input  logic [7:0]        req_len,
  output logic              req_ack,
  input  logic              dat_valid,
  input  logic [FLIT_W-4:0] dat,
  output logic              dat_ready,
  input  logic              out_full,
  output logic              out_valid,
  output logic [FLIT_W-1:0] flit_out,
  output logic              busy,
  output logic [15:0]       pkt_cnt
);

  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_TAIL} state_t;

  state_t              state_q, state_d;
  logic [3:0]          dst_q, src_q;
  logic [7:0]          len_q, rem_q;
  logic                ack_q, ov_q;
  logic [FLIT_W-1:0]   flit_q;
  logic [15:0]         cnt_q;
  logic [FLIT_W-4:0]   tail_field;
  logic [7:0]          len_clamped;

  logic xfer, accept, load_hdr, load_pay, load_tail, tail_done;

  // A flit leaves the output register only when the router FIFO can take it.
  assign xfer = ov_q & ~out_full;
  assign len_clamped = (int'(req_len) > MAX_LEN) ? 8'(MAX_LEN) : req_len;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req)  state_d = S_HDR;
      S_HDR:  if (xfer) state_d = (len_q == 8'd0) ? S_TAIL : S_PAY;
      // rem_q reaches zero when the last payload is loaded; leave once it drains.
      S_PAY:  if (xfer && rem_q == 8'd0) state_d = S_TAIL;
      S_TAIL: if (xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept    = 1'b0;
    load_hdr  = 1'b0;
    load_pay  = 1'b0;
    load_tail = 1'b0;
    tail_done = 1'b0;
    case (state_q)
      S_IDLE: accept    = req;
      S_HDR:  load_hdr  = ~ov_q;
      // Refill in the same cycle the current flit drains to sustain 1 flit/cycle.
      S_PAY:  load_pay  = (rem_q != 8'd0) & (~ov_q | xfer) & dat_valid;
      S_TAIL: begin
        load_tail = ~ov_q;
        tail_done = xfer;
      end
      default: ;
    endcase
  end

`ifdef NI_CHECKSUM_EN
  logic [FLIT_W-4:0] chk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          chk_q <= '0;
    else if (accept)   chk_q <= '0;
    else if (load_pay) chk_q <= chk_q ^ dat;
  end

  assign tail_field = chk_q;
`else
  assign tail_field = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_q  <= '0;
      src_q  <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      ack_q  <= 1'b0;
      ov_q   <= 1'b0;
      flit_q <= '0;
      cnt_q  <= '0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        dst_q <= req_dst;
        src_q <= cur_addr;
        len_q <= len_clamped;
        rem_q <= len_clamped;
      end
      if (load_pay) rem_q <= rem_q - 8'd1;

      // flit_q keeps its last value after draining; only out_valid drops.
      if (load_hdr) begin
        ov_q   <= 1'b1;
        flit_q <= {ID_HEADER, dst_q, src_q, len_q, {(FLIT_W-19){1'b0}}};
      end else if (load_pay) begin
        ov_q   <= 1'b1;
        flit_q <= {ID_PAYLOAD, dat};
      end else if (load_tail) begin
        ov_q   <= 1'b1;
        flit_q <= {ID_TAIL, tail_field};
      end else if (xfer) begin
        ov_q   <= 1'b0;
      end

      if (tail_done) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign req_ack   = ack_q;
  assign dat_ready = load_pay;
  assign out_valid = ov_q;
  assign flit_out  = flit_q;
  assign busy      = (state_q != S_IDLE);
  assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// tb/tb_ni_packetizer.sv - directed self-checking bench for ni_packetizer
module tb_ni_packetizer;

`ifdef NI_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cur_addr = 4'h5;
  logic        req = 1'b0;
  logic [3:0]  req_dst = '0;
  logic [7:0]  req_len = '0;
  logic        req_ack;
  logic        dat_valid = 1'b0;
  logic [28:0] dat = '0;
  logic        dat_ready;
  logic        out_full = 1'b0;
  logic        out_valid;
  logic [31:0] flit_out;
  logic        busy;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  ni_packetizer dut (
    .clk(clk), .rst(rst), .cur_addr(cur_addr),
    .req(req), .req_dst(req_dst), .req_len(req_len), .req_ack(req_ack),
    .dat_valid(dat_valid), .dat(dat), .dat_ready(dat_ready),
    .out_full(out_full), .out_valid(out_valid), .flit_out(flit_out),
    .busy(busy), .pkt_cnt(pkt_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] flits[$];
  logic [31:0] exp_f[8];
  logic [28:0] feed[8];
  int          feed_n = 0;
  int          feed_idx = 0;
  int          dr_cnt = 0;
  logic        took;

  task automatic drive_feed();
    dat_valid = (feed_idx < feed_n);
    dat = (feed_idx < feed_n) ? feed[feed_idx] : 29'h0;
  endtask

  // Record transfers and dat_ready at negedge; advance the payload source just after the edge.
  always begin
    @(negedge clk);
    if (rst && out_valid && !out_full) flits.push_back(flit_out);
    took = dat_ready;
    if (dat_ready) dr_cnt++;
    @(posedge clk);
    #1;
    if (took) feed_idx++;
    drive_feed();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_feed(input int n, input logic [28:0] a, input logic [28:0] b, input logic [28:0] c);
    feed[0] = a; feed[1] = b; feed[2] = c;
    feed_n = n;
    feed_idx = 0;
    drive_feed();
  endtask

  task automatic send(input logic [3:0] d, input logic [7:0] l);
    logic ok;
    ok = 1'b0;
    req_dst = d;
    req_len = l;
    req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req_ack) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    check("ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic expect_pkt(input string tag, input int n);
    check($sformatf("%s_count", tag), 32'(flits.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < flits.size()) check($sformatf("%s_f%0d", tag, i), flits[i], exp_f[i]);
  endtask

  initial begin
    logic [31:0] hold_f;
    logic        hold_v;
    logic        ok;
    int          errs, dr0;

    // Reset state
    repeat (2) tick();
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_dat_ready", 32'(dat_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flit_out", flit_out, 32'h0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    // T2: basic 2-payload packet, header latency after ack
    set_feed(2, 29'h1, 29'h2, 29'h0);
    flits.delete();
    send(4'hA, 8'd2);
    check("t2_ov_at_ack", 32'(out_valid), 32'd0);
    tick();
    check("t2_hdr_valid", 32'(out_valid), 32'd1);
    check("t2_hdr_flit", flit_out, 32'h34A04000);
    wait_idle();
    exp_f[0] = 32'h34A04000;
    exp_f[1] = 32'h40000001;
    exp_f[2] = 32'h40000002;
    exp_f[3] = 32'h80000000 | (CK ? 32'h3 : 32'h0);
    expect_pkt("t2", 4);
    check("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // T3: zero-length packet addressed to self
    set_feed(0, 29'h0, 29'h0, 29'h0);
    flits.delete();
    dr0 = dr_cnt;
    send(4'h5, 8'd0);
    wait_idle();
    exp_f[0] = 32'h2AA00000;
    exp_f[1] = 32'h80000000;
    expect_pkt("t3", 2);
    check("t3_no_dat_ready", 32'(dr_cnt - dr0), 32'd0);
    check("t3_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // T4: 5-cycle back-pressure during payload
    set_feed(3, 29'h0ABCDE01, 29'h12345678, 29'h7);
    flits.delete();
    send(4'hA, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (flits.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_reached_pay", 32'(ok), 32'd1);
    out_full = 1'b1;
    hold_f = flit_out;
    hold_v = out_valid;
    dr0 = dr_cnt;
    errs = 0;
    repeat (5) begin
      tick();
      if (flit_out !== hold_f || out_valid !== hold_v) errs++;
    end
    check("t4_hold_valid", 32'(hold_v), 32'd1);
    check("t4_hold_flit", hold_f, 32'h52345678);
    check("t4_stable", 32'(errs), 32'd0);
    check("t4_no_ready", 32'(dr_cnt - dr0), 32'd0);
    out_full = 1'b0;
    wait_idle();
    exp_f[0] = 32'h34A06000;
    exp_f[1] = 32'h4ABCDE01;
    exp_f[2] = 32'h52345678;
    exp_f[3] = 32'h40000007;
    exp_f[4] = 32'h80000000 | (CK ? 32'h1888887E : 32'h0);
    expect_pkt("t4", 5);
    check("t4_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // T5: second request held while busy
    set_feed(3, 29'h11, 29'h22, 29'h33);
    flits.delete();
    send(4'h3, 8'd2);
    req_dst = 4'hC;
    req_len = 8'd1;
    req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (req_ack) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
    check("t5_ack2_seen", 32'(ok), 32'd1);
    check("t5_ack_after_first", 32'(flits.size()), 32'd4);
    wait_idle();
    exp_f[0] = 32'h26A04000;
    exp_f[1] = 32'h40000011;
    exp_f[2] = 32'h40000022;
    exp_f[3] = 32'h80000000 | (CK ? 32'h33 : 32'h0);
    exp_f[4] = 32'h38A02000;
    exp_f[5] = 32'h40000033;
    exp_f[6] = 32'h80000000 | (CK ? 32'h33 : 32'h0);
    expect_pkt("t5", 7);
    check("t5_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // T1: reset in the middle of a packet
    set_feed(3, 29'h100, 29'h200, 29'h300);
    send(4'h6, 8'd3);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_req_ack", 32'(req_ack), 32'd0);
    check("mid_rst_dat_ready", 32'(dat_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_flit_out", flit_out, 32'h0);
    check("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    tick();
    rst = 1'b1;
    set_feed(0, 29'h0, 29'h0, 29'h0);
    flits.delete();
    repeat (5) tick();
    check("post_rst_no_flit", 32'(flits.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // T6: pkt_cnt wrap
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    check("t6_preload", 32'(pkt_cnt), 32'h0000FFFF);
    send(4'h1, 8'd0);
    wait_idle();
    check("t6_wrap", 32'(pkt_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
